booth_mul_sched: RTL and testbench

Shares one sequential radix-2 Booth multiplier datapath among NREQ requesters.
- A round-robin arbiter picks one pending request and latches its operands.
- The controller runs W Booth iterations, one per clock, then presents the signed product with the requester's ID on a valid/ready response port.
- Sits between the datapath clients and the multiplier; sole owner of the multiplier's sequencing.

---
 rtl/booth_pkg.sv | 41 ++++
 rtl/booth_step.sv | 31 +++
 rtl/booth_mul_sched.sv | 139 +++++++++++++
 tb/tb_booth_mul_sched.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the shared Booth multiplier scheduler.
package booth_pkg;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand width.
    localparam int BOOTH_W = 8;

    // Widest requester vector the arbiter helper handles.
    localparam int NREQ_MAX = 8;

    // Index of the first set bit of vld at or above ptr, wrapping at nreq.
    // Returns 0 when nothing is set; callers qualify with |vld.
    function automatic logic [2:0] rr_first(
        input logic [NREQ_MAX-1:0] vld,
        input logic [2:0]          ptr,
        input int                  nreq
    );
        logic [2:0] pick;
        logic [2:0] idx3;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            idx  = (int'(ptr) + i) % nreq;
            idx3 = 3'(idx);
            if (!found && (i < nreq) && vld[idx3]) begin
                pick  = idx3;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// then arithmetic shift right of {A,Q,Qm1}. Purely combinational.
module booth_step
    import booth_pkg::*;
#(
    parameter int W = BOOTH_W
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] q,
    input  logic         qm1,
    input  logic [W:0]   m,
    output logic [W:0]   a_next,
    output logic [W-1:0] q_next,
    output logic         qm1_next
);

    logic [W:0] sum;

    // Booth recoding of the two low multiplier bits selects -M, +M or 0.
    always_comb begin
        case ({q[0], qm1})
            2'b10:   sum = a - m;
            2'b01:   sum = a + m;
            default: sum = a;
        endcase
    end

    // Shift right by one; the A sign bit is replicated, the old Qm1 drops out.
    assign {a_next, q_next, qm1_next} = {sum[W], sum, q};

endmodule

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one sequential Booth multiplier among
// NREQ requesters, with a valid/ready response port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrating; req_ready strobes the granted requester
// RUN   | one Booth iteration per clock, count tracks remaining steps
// DONE  | product and requester ID held on the response port
module booth_mul_sched
    import booth_pkg::*;
#(
    parameter  int W    = BOOTH_W,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_m,
    input  logic [NREQ*W-1:0] req_q,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_product,
    input  logic              rsp_ready,
    output logic              busy
);

    localparam int CW = $clog2(W + 1);

    state_t         state;
    state_t         state_nxt;
    logic [W:0]     a_r;
    logic [W:0]     m_r;
    logic [W-1:0]   q_r;
    logic           qm1_r;
    logic [W:0]     a_stp;
    logic [W-1:0]   q_stp;
    logic           qm1_stp;
    logic [CW-1:0]  count;
    logic [IDW-1:0] tag;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [W-1:0]   m_sel;
    logic [W-1:0]   q_sel;
    logic           any_vld;
    logic           take;

    assign any_vld = |req_valid;
    assign grant   = IDW'(rr_first(NREQ_MAX'(req_valid), 3'(rr_ptr), NREQ));
    assign m_sel   = req_m[grant*W +: W];
    assign q_sel   = req_q[grant*W +: W];

    booth_step #(.W(W)) u_step (
        .a        (a_r),
        .q        (q_r),
        .qm1      (qm1_r),
        .m        (m_r),
        .a_next   (a_stp),
        .q_next   (q_stp),
        .qm1_next (qm1_stp)
    );

    // Next-state and grant decode; a grant is never offered while rst is high.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (any_vld && !rst) begin
                    req_ready[grant] = 1'b1;
                    take             = 1'b1;
                    state_nxt        = RUN;
                end
            end
            RUN: begin
                if (count == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture at grant and Booth iteration while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            m_r   <= '0;
            q_r   <= '0;
            qm1_r <= 1'b0;
            count <= '0;
            tag   <= '0;
        end else if (take) begin
            a_r   <= '0;
            m_r   <= {m_sel[W-1], m_sel};
            q_r   <= q_sel;
            qm1_r <= 1'b0;
            count <= CW'(W);
            tag   <= grant;
        end else if (state == RUN) begin
            a_r   <= a_stp;
            q_r   <= q_stp;
            qm1_r <= qm1_stp;
            count <= count - CW'(1);
        end
    end

    // Round-robin pointer moves just past the requester that won.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (take) begin
            rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
        end
    end

    // The response port is gated by DONE so it reads zero at all other times.
    assign busy        = (state != IDLE);
    assign rsp_valid   = (state == DONE);
    assign rsp_id      = rsp_valid ? tag : '0;
    assign rsp_product = rsp_valid ? {a_r[W-1:0], q_r} : '0;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Self-checking bench for booth_mul_sched: randomized and directed requests
// compared against a plain-arithmetic product and round-robin model.
module tb_booth_mul_sched;

    localparam int W    = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_m;
    logic [NREQ*W-1:0] req_q;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [2*W-1:0]    rsp_product;
    logic              rsp_ready;
    logic              busy;

    int n_vec   = 0;
    int n_err   = 0;
    int mdl_ptr = 0;

    booth_mul_sched #(.W(W), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_m       (req_m),
        .req_q       (req_q),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference signed product, truncated to the 2W-bit port.
    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] m,
                                               input logic signed [W-1:0] q);
        longint p;
        p = longint'(m) * longint'(q);
        return p[2*W-1:0];
    endfunction

    // Reference arbiter: first valid requester at or after ptr, wrapping.
    function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        mdl_ptr = 0;
    endtask

    // One isolated request from requester idx, full latency and result check.
    task automatic run_single(input int idx, input logic signed [W-1:0] m,
                              input logic signed [W-1:0] q);
        logic [2*W-1:0] exp_p;
        int g;
        int lat;
        @(negedge clk);
        req_valid           = '0;
        req_valid[idx]      = 1'b1;
        req_m[idx*W +: W]   = m;
        req_q[idx*W +: W]   = q;
        rsp_ready           = 1'b1;
        exp_p               = ref_mul(m, q);
        g                   = ref_pick(req_valid, mdl_ptr);
        #1;
        n_vec++;
        if (req_ready !== NREQ'(1 << g)) begin
            n_err++;
            $display("FAIL single_grant: req_ready=%b expected %b", req_ready, NREQ'(1 << g));
        end
        mdl_ptr = (g + 1) % NREQ;
        @(negedge clk);
        req_valid = '0;
        req_m     = $urandom;
        req_q     = $urandom;
        lat       = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (lat != W + 1) begin
            n_err++;
            $display("FAIL single_latency: rsp_valid in cycle %0d expected %0d", lat, W + 1);
        end
        n_vec++;
        if (rsp_product !== exp_p) begin
            n_err++;
            $display("FAIL single_product: m=%0d q=%0d got %h expected %h", m, q, rsp_product, exp_p);
        end
        n_vec++;
        if (rsp_id !== IDW'(g)) begin
            n_err++;
            $display("FAIL single_id: got %0d expected %0d", rsp_id, g);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_return_idle: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: rsp_valid=%b busy=%b req_ready=%b expected 0 0 0000",
                     rsp_valid, busy, req_ready);
        end
        n_vec++;
        if (rsp_id !== '0 || rsp_product !== '0) begin
            n_err++;
            $display("FAIL reset_data: rsp_id=%0d rsp_product=%h expected 0 0000", rsp_id, rsp_product);
        end
        req_valid = '0;
        rst       = 1'b0;
        mdl_ptr   = 0;
    endtask

    task automatic test_single();
        run_single(0, 8'sd3, 8'sd5);
        n_vec++;
        if (ref_mul(8'sd3, 8'sd5) !== 16'h000F || mdl_ptr != 1) begin
            n_err++;
            $display("FAIL single_model: ptr=%0d expected 1", mdl_ptr);
        end
    endtask

    task automatic test_corners();
        logic signed [W-1:0] cm [4];
        logic signed [W-1:0] cq [4];
        cm = '{-8'sd128, -8'sd128, 8'sd0,  -8'sd1};
        cq = '{-8'sd128,  8'sd127, -8'sd1, -8'sd1};
        for (int i = 0; i < 4; i++) begin
            run_single(i % NREQ, cm[i], cq[i]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_single(int'($urandom_range(0, NREQ - 1)), W'($urandom), W'($urandom));
        end
    endtask

    // All requesters valid: strict rotation, operands sampled only at grant.
    task automatic test_all_four();
        logic signed [W-1:0] om [NREQ];
        logic signed [W-1:0] oq [NREQ];
        logic [2*W-1:0] exp_p;
        int g;
        int cnt;
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            om[i]             = W'($urandom);
            oq[i]             = W'(i * 37 + 11);
            req_m[i*W +: W]   = om[i];
            req_q[i*W +: W]   = oq[i];
        end
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        for (int k = 0; k < NREQ + 1; k++) begin
            cnt = 0;
            while (req_ready === '0 && cnt < 20) begin
                @(negedge clk);
                #1;
                cnt++;
            end
            if (k > 0) begin
                n_vec++;
                if (cnt != 1) begin
                    n_err++;
                    $display("FAIL rr_gap: next grant after %0d cycles expected 1", cnt);
                end
            end
            g     = ref_pick(req_valid, mdl_ptr);
            exp_p = ref_mul(om[g], oq[g]);
            n_vec++;
            if (req_ready !== NREQ'(1 << g)) begin
                n_err++;
                $display("FAIL rr_grant: step %0d req_ready=%b expected %b", k, req_ready, NREQ'(1 << g));
            end
            mdl_ptr = (g + 1) % NREQ;
            @(negedge clk);
            om[g]           = W'($urandom);
            oq[g]           = W'($urandom);
            req_m[g*W +: W] = om[g];
            req_q[g*W +: W] = oq[g];
            cnt = 0;
            while (rsp_valid !== 1'b1 && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            n_vec++;
            if (rsp_id !== IDW'(g) || rsp_product !== exp_p) begin
                n_err++;
                $display("FAIL rr_result: step %0d id=%0d product=%h expected %0d %h",
                         k, rsp_id, rsp_product, g, exp_p);
            end
        end
        @(negedge clk);
        req_valid = '0;
        repeat (W + 3) @(negedge clk);
        apply_reset();
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] exp_p;
        logic signed [W-1:0] m;
        logic signed [W-1:0] q;
        int cnt;
        m = -8'sd77;
        q = 8'sd93;
        exp_p = ref_mul(m, q);
        @(negedge clk);
        req_valid       = 4'b0010;
        req_m[W +: W]   = m;
        req_q[W +: W]   = q;
        rsp_ready       = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_grant: req_ready=%b expected 0010", req_ready);
        end
        mdl_ptr = 2;
        @(negedge clk);
        req_valid = '1;
        cnt = 0;
        while (rsp_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(1) || rsp_product !== exp_p
                || req_ready !== '0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d valid=%b id=%0d product=%h ready=%b busy=%b expected 1 1 %h 0000 1",
                         k, rsp_valid, rsp_id, rsp_product, req_ready, busy, exp_p);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        #1;
        n_vec++;
        if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_before_accept: rsp_valid=%b expected 1", rsp_valid);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_complete: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [2*W-1:0] exp_p;
        int g;
        int cnt;
        run_single(1, W'($urandom), W'($urandom));
        @(negedge clk);
        req_valid      = 4'b0101;
        req_m[0 +: W]  = 8'sd100;
        req_q[0 +: W]  = -8'sd3;
        req_m[2*W +: W] = 8'sd9;
        req_q[2*W +: W] = 8'sd9;
        rsp_ready      = 1'b1;
        g              = ref_pick(req_valid, mdl_ptr);
        #1;
        n_vec++;
        if (req_ready !== NREQ'(1 << g)) begin
            n_err++;
            $display("FAIL rst_run_grant: req_ready=%b expected %b", req_ready, NREQ'(1 << g));
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL rst_run_busy: cycle %0d rsp_valid=%b busy=%b expected 0 1", c, rsp_valid, busy);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
            n_err++;
            $display("FAIL rst_run_abort: rsp_valid=%b busy=%b req_ready=%b expected 0 0 0000",
                     rsp_valid, busy, req_ready);
        end
        rst     = 1'b0;
        mdl_ptr = 0;
        g       = ref_pick(req_valid, mdl_ptr);
        exp_p   = ref_mul(8'sd100, -8'sd3);
        #1;
        n_vec++;
        if (req_ready !== NREQ'(1 << g)) begin
            n_err++;
            $display("FAIL rst_run_regrant: req_ready=%b expected %b", req_ready, NREQ'(1 << g));
        end
        mdl_ptr = (g + 1) % NREQ;
        @(negedge clk);
        req_valid = '0;
        cnt = 1;
        while (rsp_valid !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++;
        if (cnt != W + 1 || rsp_id !== IDW'(g) || rsp_product !== exp_p) begin
            n_err++;
            $display("FAIL rst_run_result: cycle %0d id=%0d product=%h expected %0d %0d %h",
                     cnt, rsp_id, rsp_product, W + 1, g, exp_p);
        end
        @(negedge clk);
    endtask

    // Stimulus sequence.
    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_m     = '0;
        req_q     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_corners();
        test_random();
        test_all_four();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time limit in case a wait loop is ever broken.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule
